add_stream_unit: RTL and testbench

Synthesizable streaming adder that sits directly downstream of the operand stimulus stage. It accepts operand pairs `a`/`b` over a valid/ready handshake and registers each sum `a + b` at full width. Sums are buffered in a 2-entry FIFO, presented on a valid/ready output, and counted. It replaces the untimed add task with a cycle-accurate, back-pressure-aware block.

---
 rtl/add_stream_pkg.sv | 21 ++
 rtl/add_stream_fifo2.sv | 82 ++++++++
 rtl/add_stream_unit.sv | 86 ++++++++
 tb/tb_add_stream_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/add_stream_pkg.sv
// Shared types for the streaming adder: default operand width, FIFO entry layout and occupancy states.
// With ADD_STREAM_TRACE_EN defined, each entry also carries its operands for the pop trace.
package add_stream_pkg;

  localparam int W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef struct packed {
`ifdef ADD_STREAM_TRACE_EN
    logic [W-1:0] a;
    logic [W-1:0] b;
`endif
    logic [W:0]   y;
  } entry_t;

endpackage

// File: rtl/add_stream_fifo2.sv
// Two-entry pointer FIFO with registered push/pop permission flags.
// The occupancy FSM drives can_push and has_data directly, so neither one depends on push or pop.
module add_stream_fifo2
  import add_stream_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          can_push,
  output logic          has_data
);

  logic [DW-1:0] mem [2];
  logic [DW-1:0] last_q;
  logic          wr_ptr;
  logic          rd_ptr;
  occ_t          state;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && can_push;
  assign do_pop  = pop && has_data;

  // When empty, keep presenting the last popped entry so the output is never stale garbage or X.
  assign rdata = has_data ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      last_q   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      state    <= EMPTY;
      can_push <= 1'b1;
      has_data <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
      case (state)
        EMPTY: begin
          if (do_push) begin
            state    <= ONE;
            has_data <= 1'b1;
          end
        end
        ONE: begin
          if (do_push && !do_pop) begin
            state    <= FULL;
            can_push <= 1'b0;
          end else if (!do_push && do_pop) begin
            state    <= EMPTY;
            has_data <= 1'b0;
          end
        end
        FULL: begin
          if (do_pop) begin
            state    <= ONE;
            can_push <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          can_push <= 1'b1;
          has_data <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/add_stream_unit.sv
// Streaming adder: accepts a/b pairs, buffers full-width sums in a 2-entry FIFO and counts traffic.
// Define ADD_STREAM_TRACE_EN to store operands per entry and print each popped entry in simulation.
module add_stream_unit
  import add_stream_pkg::*;
#(
  parameter int W     = add_stream_pkg::W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_y,
  input  logic             clr,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] carry_count
);

  // The entry layout lives in the package, so W is expected to match add_stream_pkg::W.
  logic [W:0] sum;
  entry_t     wr_entry;
  entry_t     head;
  logic       push;
  logic       pop;

  assign sum  = {1'b0, in_a} + {1'b0, in_b};
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_entry   = '0;
    wr_entry.y = sum;
`ifdef ADD_STREAM_TRACE_EN
    wr_entry.a = in_a;
    wr_entry.b = in_b;
`endif
  end

  add_stream_fifo2 #(
    .DW($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_entry),
    .rdata   (head),
    .can_push(in_ready),
    .has_data(out_valid)
  );

  assign out_y = head.y;

  // Clear wins over a same-cycle increment; both counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count   <= '0;
      carry_count <= '0;
    end else if (clr) begin
      txn_count   <= '0;
      carry_count <= '0;
    end else begin
      if (pop) begin
        txn_count <= txn_count + CNT_W'(1);
      end
      if (push && sum[W]) begin
        carry_count <= carry_count + CNT_W'(1);
      end
    end
  end

`ifdef ADD_STREAM_TRACE_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && pop) begin
      $display("a : %0d and b : %0d and y : %0d", head.a, head.b, head.y);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_add_stream_unit.sv
// Scoreboard bench for add_stream_unit: expected sums queued on accept, compared on each output handshake.
module tb_add_stream_unit;

  localparam int W     = 4;
  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W:0]       out_y;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] txn_count;
  logic [CNT_W-1:0] carry_count;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int exp_txn = 0;
  int exp_carry = 0;

  add_stream_unit #(
    .W(W),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .clr        (clr),
    .txn_count  (txn_count),
    .carry_count(carry_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then model whatever handshakes the next rising edge will take.
  task automatic applyStimulus(input logic v, input int a, input int b, input logic r, input logic c);
    int  sum;
    logic fire_in;
    logic fire_out;
    @(negedge clk);
    in_valid  = v;
    in_a      = a[W-1:0];
    in_b      = b[W-1:0];
    out_ready = r;
    clr       = c;
    #1;
    sum      = a + b;
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    if (fire_out) begin
      if (sb.size() == 0) checkOutput("unexpected_out", 1, 0);
      else checkOutput("out_y", int'(out_y), sb.pop_front());
    end
    if (c) begin
      exp_txn   = 0;
      exp_carry = 0;
    end else begin
      if (fire_out) exp_txn = (exp_txn + 1) % CMOD;
      if (fire_in && sum >= 16) exp_carry = (exp_carry + 1) % CMOD;
    end
    if (fire_in) sb.push_back(sum);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("drained", sb.size(), 0);
  endtask

  task automatic checkCounters(input string tag);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    checkOutput({tag, "_txn"}, int'(txn_count), exp_txn);
    checkOutput({tag, "_carry"}, int'(carry_count), exp_carry);
    checkOutput({tag, "_idle_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    int c0;
    int ra;
    int rb;

    // Reset state with no clock edge required
    #12;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_y", int'(out_y), 0);
    checkOutput("rst_txn", int'(txn_count), 0);
    checkOutput("rst_carry", int'(carry_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single transfer and one-cycle latency
    applyStimulus(1'b1, 1, 3, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("lat_valid", int'(out_valid), 1);
    checkCounters("single");
    checkOutput("single_txn_abs", int'(txn_count), 1);
    checkOutput("single_carry_abs", int'(carry_count), 0);

    // Back-pressure: fill, hold the third pair, then release in order
    applyStimulus(1'b1, 5, 6, 1'b0, 1'b0);
    applyStimulus(1'b1, 7, 8, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 2, 1'b0, 1'b0);
    checkOutput("bp_full_ready", int'(in_ready), 0);
    applyStimulus(1'b1, 1, 2, 1'b0, 1'b0);
    checkOutput("bp_hold_valid", int'(out_valid), 1);
    checkOutput("bp_hold_y", int'(out_y), 11);
    applyStimulus(1'b1, 1, 2, 1'b1, 1'b0);
    checkOutput("bp_pop_ready", int'(in_ready), 0);
    applyStimulus(1'b1, 1, 2, 1'b1, 1'b0);
    checkOutput("bp_ready_back", int'(in_ready), 1);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    drain();
    checkCounters("bp");

    // Carry and full-width sums
    c0 = exp_carry;
    applyStimulus(1'b1, 15, 15, 1'b1, 1'b0);
    applyStimulus(1'b1, 8, 8, 1'b1, 1'b0);
    applyStimulus(1'b1, 7, 8, 1'b1, 1'b0);
    drain();
    checkCounters("carry");
    checkOutput("carry_delta", int'(carry_count), (c0 + 2) % CMOD);

    // Simultaneous push and pop at occupancy one
    applyStimulus(1'b1, 3, 4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      applyStimulus(1'b1, ra, rb, 1'b1, 1'b0);
      checkOutput("sim_occ", int'(dut.u_fifo.state), 1);
      checkOutput("sim_ready", int'(in_ready), 1);
    end
    drain();
    checkCounters("sim");

    // Counter wrap after 16 pops, then clear beating a same-cycle pop
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, i, 1, 1'b1, 1'b0);
    end
    drain();
    checkCounters("wrap");
    checkOutput("wrap_txn_zero", int'(txn_count), 0);
    applyStimulus(1'b1, 2, 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    checkCounters("clr");
    checkOutput("clr_prio", int'(txn_count), 0);

    // Asynchronous reset mid-stream with two entries buffered
    applyStimulus(1'b1, 9, 9, 1'b1, 1'b0);
    applyStimulus(1'b1, 9, 8, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("pre_rst_full", int'(in_ready), 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", int'(out_valid), 0);
    checkOutput("mid_rst_in_ready", int'(in_ready), 1);
    checkOutput("mid_rst_txn", int'(txn_count), 0);
    checkOutput("mid_rst_carry", int'(carry_count), 0);
    sb.delete();
    exp_txn   = 0;
    exp_carry = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 2, 5, 1'b1, 1'b0);
    drain();
    checkCounters("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
